// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: LCD-side model of a 4/8-bit HD44780 bus, decoding E strobes into bytes and answering status reads.
// Ports: clk/rst_n clock and async active-low reset; lcd_e/lcd_rs/lcd_rw/lcd_data_in pins from the initiator;
// lcd_data_out/lcd_data_oe read-back nibble and its drive enable; byte_valid/byte_data/byte_rs/overrun completed
// write bytes; busy, addr_counter and four_bit_mode expose the controller state.
module lcd_hd44780_responder #(
  parameter int SYNC_STAGES       = 2,
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_data_in,
  output logic [3:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       overrun,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic       four_bit_mode
);
  localparam int MAX_BUSY = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
  localparam int CW = $clog2(MAX_BUSY + 1);
  // Each synchronizer stage carries {e, rs, rw, data[3:0]}.
  logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
  logic          e_prev_q, e_prev_d;
  logic          phase_q, phase_d;
  logic [3:0]    hi_q, hi_d;
  logic          four_q, four_d;
  logic [6:0]    ac_q, ac_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bv_q, bv_d;
  logic [7:0]    bd_q, bd_d;
  logic          brs_q, brs_d;
  logic          ovr_q, ovr_d;
  logic          e_s, rs_s, rw_s;
  logic [3:0]    d_s;
  logic          strobe, complete, busy_w;
  logic [7:0]    byte_in;
  assign {e_s, rs_s, rw_s, d_s} = sync_q[SYNC_STAGES-1];
  assign strobe   = e_prev_q & ~e_s;
  // A write completes a byte at once in 8-bit mode, or on the second nibble in 4-bit mode.
  assign complete = strobe & ~rw_s & (~four_q | phase_q);
  assign byte_in  = four_q ? {hi_q, d_s} : {d_s, 4'h0};
  assign busy_w   = cnt_q != '0;
  always_comb begin
    sync_d[0] = {lcd_e, lcd_rs, lcd_rw, lcd_data_in};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_comb begin
    e_prev_d = e_s;
    hi_d     = (strobe & four_q & ~phase_q) ? d_s : hi_q;
    phase_d  = (strobe & four_q) ? ~phase_q : phase_q;
    four_d   = four_q;
    ac_d     = ac_q;
    cnt_d    = busy_w ? cnt_q - CW'(1) : cnt_q;
    bv_d     = complete;
    bd_d     = complete ? byte_in : bd_q;
    brs_d    = complete ? rs_s : brs_q;
    ovr_d    = complete & busy_w;
    // A completed byte always reloads the counter, overriding the decrement.
    if (complete) begin
      cnt_d = CW'(BUSY_CYCLES);
      if (rs_s) ac_d = ac_q + 7'd1;
      else if (byte_in == 8'h01 || byte_in[7:1] == 7'h01) begin
        ac_d  = '0;
        cnt_d = CW'(CLEAR_BUSY_CYCLES);
      end
      else if (byte_in[7]) ac_d = byte_in[6:0];
      else if (byte_in[7:5] == 3'b001) begin
        four_d  = ~byte_in[4];
        phase_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      e_prev_q <= 1'b0;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      four_q   <= 1'b0;
      ac_q     <= '0;
      cnt_q    <= '0;
      bv_q     <= 1'b0;
      bd_q     <= '0;
      brs_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      e_prev_q <= e_prev_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      four_q   <= four_d;
      ac_q     <= ac_d;
      cnt_q    <= cnt_d;
      bv_q     <= bv_d;
      bd_q     <= bd_d;
      brs_q    <= brs_d;
      ovr_q    <= ovr_d;
    end
  end
  // Status nibble first (busy + AC high bits), then AC low bits on the second 4-bit read.
  assign lcd_data_oe   = rw_s & e_s;
  assign lcd_data_out  = !lcd_data_oe ? 4'h0 : (four_q & phase_q) ? ac_q[3:0] : {busy_w, ac_q[6:4]};
  assign byte_valid    = bv_q;
  assign byte_data     = bd_q;
  assign byte_rs       = brs_q;
  assign overrun       = ovr_q;
  assign busy          = busy_w;
  assign addr_counter  = ac_q;
  assign four_bit_mode = four_q;
endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- LCD-side responder for the 4-bit HD44780 bus that firmware bit-bangs through PORTA (DATA[3:0], RS, RW, E).
- Synthesizable. Sits on the LCD pins, decodes E strobes into bytes and tracks the address counter and busy flag.
- Answers status reads, so firmware LCD drivers can run on-chip or in simulation without a physical panel.
- Decoded bytes are presented on a strobe interface for a display mirror or scoreboard.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every LCD input.
- BUSY_CYCLES, 2000, busy duration in clk cycles for ordinary commands and data writes (40 us at 50 MHz).
- CLEAR_BUSY_CYCLES, 82000, busy duration for clear display and return home.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_e  in  1  enable strobe from the initiator
- lcd_rs  in  1  register select (0 = command, 1 = data)
- lcd_rw  in  1  1 = read, 0 = write
- lcd_data_in  in  4  DATA[3:0] as driven by the initiator
- lcd_data_out  out  4  read-back nibble
- lcd_data_oe  out  1  drive enable for lcd_data_out
- byte_valid  out  1  one-cycle strobe when a write byte completes
- byte_data  out  8  completed byte, held until the next strobe
- byte_rs  out  1  RS of the completed byte
- overrun  out  1  one-cycle pulse, coincident with byte_valid, when the byte arrived while busy = 1
- busy  out  1  busy flag
- addr_counter  out  7  DDRAM address counter
- four_bit_mode  out  1  1 once function set with DL = 0 has been received

Behaviour:
- Reset (async, rst_n = 0): all outputs 0, mode = 8-bit, nibble phase = 0, busy counter = 0, synchronizers cleared.
- Input capture: all inputs pass through SYNC_STAGES flops.
  - A strobe is e_sync_prev = 1 and e_sync = 0.
  - RS, RW and DATA are captured from the synchronized values in the strobe cycle.
- 8-bit mode write strobe: byte = {DATA, 4'h0}, completed immediately.
- 4-bit mode write strobe:
  - phase 0: store high nibble, go to phase 1.
  - phase 1: byte = {high, DATA}, go to phase 0.
- Byte completion: byte_valid, byte_data, byte_rs and overrun are registered 1 cycle after the strobe. The decode effects below take hold in that same cycle.
- Decode, highest priority first:
  - rs = 1 (data write): AC <= AC + 1, wrapping 0x7F to 0x00; load BUSY_CYCLES.
  - 0x01 (clear display): AC <= 0; load CLEAR_BUSY_CYCLES.
  - 0x02 or 0x03 (return home): AC <= 0; load CLEAR_BUSY_CYCLES.
  - 8'b1aaaaaaa (set DDRAM address): AC <= aaaaaaa; load BUSY_CYCLES.
  - 8'b001dxxxx (function set): four_bit_mode <= ~d; phase <= 0; load BUSY_CYCLES.
  - Any other command: load BUSY_CYCLES only.
- Busy counter:
  - busy = (counter != 0); the counter decrements every cycle to 0.
  - A new byte reloads the counter even while busy. It is never ignored, and overrun flags it.
- Read (synchronized rw = 1):
  - lcd_data_oe = 1 while e_sync = 1, else 0.
  - Read-back nibble is {busy, AC[6:4]} in 8-bit mode or 4-bit phase 0, and AC[3:0] in phase 1.
  - A read strobe toggles the phase in 4-bit mode and does not produce byte_valid.
- Mixed transactions: the phase advances on every strobe regardless of RW or RS changes between nibbles. The byte takes RS from its second nibble.
- Mode switch: after function set DL = 0 is received in 8-bit mode, the next strobe is treated as a high nibble. Function set DL = 1 in 4-bit mode returns to 8-bit after the full byte.
- Simultaneous strobe and counter expiry: the reload wins.
- Reset mid-byte discards the stored high nibble.

Test Plan:
1. Release reset with inputs idle -> all outputs 0, four_bit_mode = 0, lcd_data_oe = 0 for 10 cycles.
2. 8-bit mode, rs = 0, DATA = 0x2, one E pulse -> byte_valid with byte_data = 0x20, four_bit_mode = 1, busy = 1 for exactly BUSY_CYCLES cycles.
3. 4-bit mode, rs = 1, nibbles 0x4 then 0x1 -> single byte_valid with 0x41 and byte_rs = 1, AC 0x00 -> 0x01, overrun = 0. Repeat while busy -> overrun = 1 and busy reloaded.
4. Command nibbles 0xC, 0x0 -> AC = 0x40. Then rw = 1 with two E pulses while busy -> lcd_data_out = 0xC then 0x0, oe asserted only while E is high.
5. Set DDRAM 0xFF (AC = 0x7F), then a data write -> AC = 0x00. Command 0x01 -> AC = 0, busy for CLEAR_BUSY_CYCLES.
6. In 4-bit mode send one nibble, pulse rst_n low mid-byte -> phase cleared, mode back to 8-bit. Next strobe with DATA = 0x3 -> byte 0x30.
